// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states and grant owner.
// Also used by the hazard unit and the bench.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  // Two-way round robin: on a tie the port not granted last wins.
  function automatic logic rr_pick(input logic inst_req, input logic data_req,
                                   input logic last_gnt);
    logic owner;
    if (inst_req && data_req) begin
      owner = (last_gnt == GNT_INST) ? GNT_DATA : GNT_INST;
    end else if (data_req) begin
      owner = GNT_DATA;
    end else begin
      owner = GNT_INST;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and bus-side signal bundle of the memory arbiter.
// slave = arbiter view, master = requesters/bus-bridge view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            inst_req;
  logic [AW-1:0]   inst_addr;
  logic [DW-1:0]   inst_rdata;
  logic            inst_ok;

  logic            data_req;
  logic            data_wr;
  logic [DW/8-1:0] data_wstrb;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic [DW-1:0]   data_rdata;
  logic            data_ok;

  logic            bus_req;
  logic            bus_wr;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_addr_ok;
  logic            bus_data_ok;
  logic [DW-1:0]   bus_rdata;

  logic            busy;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_ok, data_rdata, data_ok,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, busy
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_ok, data_rdata, data_ok,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter_flop.sv
// Enable flop with asynchronous active-high reset to zero.
module mem_arbiter_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;

  // Load on enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end else begin
      val_q <= val_q;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between instruction fetch and data memory,
// one transaction at a time: grant, address phase, data phase, one-cycle ok.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_if
);

  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + AW + DW;

  arb_state_e    state_q;
  logic          owner_q;
  logic          last_q;
  logic          bus_req_q;
  logic          busy_q;
  logic          inst_ok_q;
  logic          data_ok_q;
  logic [DW-1:0] inst_rdata_q;
  logic [DW-1:0] data_rdata_q;

  logic          grant_s;
  logic          gnt_owner_s;
  logic [CW-1:0] cap_d;
  logic [CW-1:0] cap_q;

  // Grant decision and capture payload; a fetch always presents a zeroed write side.
  always_comb begin
    grant_s     = 1'b0;
    gnt_owner_s = GNT_INST;
    cap_d       = '0;
    if ((state_q == ST_IDLE) && (bus_if.inst_req || bus_if.data_req)) begin
      grant_s     = 1'b1;
      gnt_owner_s = rr_pick(bus_if.inst_req, bus_if.data_req, last_q);
      if (gnt_owner_s == GNT_DATA) begin
        cap_d = {bus_if.data_wr, bus_if.data_wstrb, bus_if.data_addr, bus_if.data_wdata};
      end else begin
        cap_d = {1'b0, {SW{1'b0}}, bus_if.inst_addr, {DW{1'b0}}};
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  mem_arbiter_flop #(.W(CW)) u_cap (
    .clk  (clk),
    .rst  (rst),
    .en_i (grant_s),
    .d_i  (cap_d),
    .q_o  (cap_q)
  );

  // Transaction FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= GNT_INST;
      last_q       <= GNT_INST;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q   <= ST_ADDR;
            owner_q   <= gnt_owner_s;
            last_q    <= gnt_owner_s;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (bus_if.bus_addr_ok) begin
            state_q   <= ST_DATA;
            bus_req_q <= 1'b0;
          end else begin
            state_q   <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (bus_if.bus_data_ok) begin
            state_q <= ST_RESP;
            if (owner_q == GNT_DATA) begin
              data_rdata_q <= bus_if.bus_rdata;
              data_ok_q    <= 1'b1;
            end else begin
              inst_rdata_q <= bus_if.bus_rdata;
              inst_ok_q    <= 1'b1;
            end
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          inst_ok_q <= 1'b0;
          data_ok_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
          inst_ok_q <= 1'b0;
          data_ok_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.bus_req    = bus_req_q;
  assign bus_if.bus_wr     = cap_q[CW-1];
  assign bus_if.bus_wstrb  = cap_q[AW+DW +: SW];
  assign bus_if.bus_addr   = cap_q[DW +: AW];
  assign bus_if.bus_wdata  = cap_q[DW-1:0];
  assign bus_if.inst_ok    = inst_ok_q;
  assign bus_if.inst_rdata = inst_rdata_q;
  assign bus_if.data_ok    = data_ok_q;
  assign bus_if.data_rdata = data_rdata_q;
  assign bus_if.busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever inst_ok or data_ok fires.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    int          cyc;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];

  mem_arbiter_if #(.AW(32), .DW(32)) bif();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [31:0] rd, input int at, input logic c);
    exp_t e;
    e.port = port; e.rdata = rd; e.cyc = at; e.chk_rdata = c;
    sb.push_back(e);
  endtask

  task automatic chk_fields(input logic e_wr, input logic [3:0] e_strb,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata);
    chk("bus_fields", {bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata},
        {e_wr, e_strb, e_addr, e_wdata});
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bif.bus_req, bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata,
             bif.inst_ok, bif.data_ok, bif.inst_rdata, bif.data_rdata, bif.busy}, '0);
  endtask

  // Bus-bridge model: waits for bus_req, then answers after the given wait cycles.
  task automatic serve(input int aw, input int dw, input logic [31:0] rd,
                       input logic noise, input logic scramble,
                       input logic e_wr, input logic [3:0] e_strb,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata);
    int n = 0;
    tick;
    while (bif.bus_req !== 1'b1) begin
      tick;
      n++;
      if (n > 50) begin
        chk("bus_req_timeout", 160'd0, 160'd1);
        return;
      end
    end
    chk_fields(e_wr, e_strb, e_addr, e_wdata);
    if (scramble) begin
      bif.data_addr  = ~bif.data_addr;
      bif.data_wdata = ~bif.data_wdata;
      bif.data_wstrb = ~bif.data_wstrb;
      bif.data_wr    = ~bif.data_wr;
    end
    for (int i = 0; i < aw; i++) begin
      if (noise) begin
        bif.bus_data_ok = 1'b1;
        bif.bus_rdata   = ~rd;
      end
      tick;
      bif.bus_data_ok = 1'b0;
      bif.bus_rdata   = 32'h0;
      chk("bus_req_addr_wait", bif.bus_req, 1'b1);
      chk_fields(e_wr, e_strb, e_addr, e_wdata);
    end
    bif.bus_addr_ok = 1'b1;
    tick;
    bif.bus_addr_ok = 1'b0;
    chk("bus_req_data_phase", bif.bus_req, 1'b0);
    chk_fields(e_wr, e_strb, e_addr, e_wdata);
    for (int i = 0; i < dw; i++) begin
      if (noise) bif.bus_addr_ok = 1'b1;
      tick;
      bif.bus_addr_ok = 1'b0;
      chk_fields(e_wr, e_strb, e_addr, e_wdata);
    end
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata   = rd;
    tick;
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata   = 32'h0;
    chk_fields(e_wr, e_strb, e_addr, e_wdata);
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bif.inst_ok === 1'b1 || bif.data_ok === 1'b1) begin
      chk("ok_exclusive", {bif.inst_ok, bif.data_ok} == 2'b11, 1'b0);
      if (sb.size() == 0) begin
        chk("ok_unexpected", {bif.inst_ok, bif.data_ok}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("ok_port", {bif.inst_ok, bif.data_ok},
            (e.port == GNT_DATA) ? 2'b01 : 2'b10);
        chk("ok_cycle", cyc, e.cyc);
        if (e.chk_rdata) begin
          chk("ok_rdata", (e.port == GNT_DATA) ? bif.data_rdata : bif.inst_rdata, e.rdata);
        end else begin
          chk("ok_rdata_known", $isunknown(bif.data_rdata), 1'b0);
        end
      end
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int c0;
    bif.inst_req = 1'b0;  bif.inst_addr = 32'h0;
    bif.data_req = 1'b0;  bif.data_wr = 1'b0;  bif.data_wstrb = 4'h0;
    bif.data_addr = 32'h0; bif.data_wdata = 32'h0;
    bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = 32'h0;

    repeat (2) tick;
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    // Tie from reset: data, inst, data with both held.
    bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC00000;
    bif.data_req = 1'b1; bif.data_wr = 1'b0; bif.data_wstrb = 4'hF;
    bif.data_addr = 32'h80000010; bif.data_wdata = 32'hCAFE0000;
    c0 = cyc;
    push(GNT_DATA, 32'hDDDD0001, c0 + 3,  1'b1);
    push(GNT_INST, 32'h11110002, c0 + 7,  1'b1);
    push(GNT_DATA, 32'hDDDD0003, c0 + 11, 1'b1);
    serve(0, 0, 32'hDDDD0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h80000010, 32'hCAFE0000);
    serve(0, 0, 32'h11110002, 1'b0, 1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0);
    serve(0, 0, 32'hDDDD0003, 1'b0, 1'b0, 1'b0, 4'hF, 32'h80000010, 32'hCAFE0000);
    bif.inst_req = 1'b0; bif.data_req = 1'b0;
    tick;
    chk("busy_idle", bif.busy, 1'b0);

    // Single fetch, minimum latency.
    bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC00000;
    c0 = cyc;
    push(GNT_INST, 32'h24080001, c0 + 3, 1'b1);
    serve(0, 0, 32'h24080001, 1'b0, 1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0);
    bif.inst_req = 1'b0;
    tick;

    // Write with waits; requester inputs scrambled after grant.
    bif.data_req = 1'b1; bif.data_wr = 1'b1; bif.data_wstrb = 4'b0011;
    bif.data_addr = 32'h80000040; bif.data_wdata = 32'h1234ABCD;
    c0 = cyc;
    push(GNT_DATA, 32'h0, c0 + 8, 1'b0);
    serve(2, 3, 32'h5555AAAA, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h80000040, 32'h1234ABCD);
    bif.data_req = 1'b0;
    tick;

    // Protocol noise on a fetch.
    bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC00100;
    c0 = cyc;
    push(GNT_INST, 32'h8C090004, c0 + 5, 1'b1);
    serve(1, 1, 32'h8C090004, 1'b1, 1'b0, 1'b0, 4'h0, 32'hBFC00100, 32'h0);
    bif.inst_req = 1'b0;
    tick;

    // Reset during DATA phase of a data read.
    bif.data_req = 1'b1; bif.data_wr = 1'b0; bif.data_wstrb = 4'hF;
    bif.data_addr = 32'h80000080; bif.data_wdata = 32'h0;
    tick;
    chk("bus_req_pre_reset", bif.bus_req, 1'b1);
    bif.bus_addr_ok = 1'b1;
    tick;
    bif.bus_addr_ok = 1'b0;
    chk("busy_in_data", bif.busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset_outputs");
    bif.data_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    // Fresh tie after reset: last-grant is back to inst, so data wins.
    bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC00200;
    bif.data_req = 1'b1; bif.data_addr = 32'h80000090;
    c0 = cyc;
    push(GNT_DATA, 32'h0F0F1234, c0 + 3, 1'b1);
    serve(0, 0, 32'h0F0F1234, 1'b0, 1'b0, 1'b0, 4'hF, 32'h80000090, 32'h0);
    bif.inst_req = 1'b0; bif.data_req = 1'b0;

    repeat (5) tick;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single external memory bus between the instruction-fetch port and the data-memory port of the five-stage pipeline. It accepts one request at a time and drives the bus through an address phase and a data phase. It then returns a one-cycle completion pulse with read data to the winning requester. It sits between the fetch/memory stages and the bus bridge; the hazard logic turns "req held without ok" into pipeline stalls.

## Interface
- AW, 32, address width
- DW, 32, data width (byte strobes are DW/8 bits)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request, held until inst_ok
- inst_addr  in  AW  fetch address, stable while inst_req
- inst_rdata  out  DW  fetch data, valid only while inst_ok
- inst_ok  out  1  one-cycle completion pulse
- data_req  in  1  data request, held until data_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DW/8  byte enables for writes
- data_addr  in  AW  data address
- data_wdata  in  DW  write data
- data_rdata  out  DW  read data, valid only while data_ok
- data_ok  out  1  one-cycle completion pulse (reads and writes)
- bus_req  out  1  bus address-phase request
- bus_wr, bus_wstrb, bus_addr, bus_wdata  out  1/DW/8/AW/DW  captured request fields
- bus_addr_ok  in  1  bus accepted address
- bus_data_ok  in  1  bus completed transfer
- bus_rdata  in  DW  bus read data, valid with bus_data_ok
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: sample inst_req/data_req.
  - If neither is asserted, stay in IDLE.
  - If exactly one is asserted, grant it.
  - If both are asserted, grant the port that was not granted last. The last-grant register resets to "inst", so data wins the first tie.
- On grant: capture wr/wstrb/addr/wdata into bus registers (inst grant: wr=0, wstrb=0, wdata=0), record grant owner, update last-grant, go to ADDR.
- ADDR: bus_req=1. On bus_addr_ok, go to DATA with bus_req=0. bus_data_ok is ignored in ADDR.
- DATA: wait for bus_data_ok. When it arrives, register bus_rdata into the owner's rdata and go to RESP.
- RESP: assert the owner's ok for exactly one cycle, then go to IDLE. Requests are not sampled in RESP; a requester may drop req or present a new request from the cycle after ok.
- bus_addr_ok outside ADDR and bus_data_ok outside DATA are ignored.
- Exactly one transaction is outstanding at a time. No request is granted while busy.
- Writes complete like reads; rdata content for a write ok is don't-care but must not be X.
- Captured bus fields stay constant from grant until return to IDLE, even if requester inputs change.

## Timing
- Reset (asynchronous): state=IDLE, last-grant=inst. All outputs are 0: bus_req, bus fields, inst_ok, data_ok, both rdata, busy. An in-flight transaction is abandoned; the bus bridge shares the same rst.
- Minimum latency: req sampled in cycle 0; bus_req=1 in cycle 1; bus_addr_ok in cycle 1 gives DATA in cycle 2; bus_data_ok in cycle 2 gives ok=1 in cycle 3; IDLE in cycle 4. This is 3 cycles from req to ok, and a 4-cycle minimum between back-to-back grants.
- Each bus wait cycle adds exactly one cycle of latency.
- inst_ok and data_ok are never asserted in the same cycle and are never asserted for more than one cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared defines header: state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3) and grant-owner encoding (GNT_INST=1'b0, GNT_DATA=1'b1), for reuse by the hazard unit and bench.
- The capture registers use the existing enable/reset flop. No new sub-module is needed; the 2-way round-robin decision is a few lines inline.

## Test plan
- Single fetch: inst_req=1, addr=0xBFC00000; bus_addr_ok and bus_data_ok immediate, rdata=0x24080001 -> inst_ok in cycle 3 with inst_rdata=0x24080001, and data_ok stays 0.
- Tie, then fairness: both req held from reset; data read 0x80000010, then fetch -> data granted first and inst second; with both held again, grants alternate data, inst, data.
- Write with waits: data_wr=1, wstrb=4'b0011, wdata=0x1234ABCD; bus_addr_ok delayed 2 cycles, bus_data_ok delayed 3 -> bus fields stable throughout, data_ok at cycle 3+5=8, exactly one pulse.
- Protocol noise: spurious bus_data_ok during ADDR and bus_addr_ok during DATA -> ignored; completion only on the proper strobe.
- Requester changes data_addr after grant -> bus_addr keeps the captured value.
- Reset mid-DATA: assert rst asynchronously -> all outputs 0 immediately; next request after reset is a fresh grant with 3-cycle minimum latency.
